// File: rtl/run_ctrl_if.sv
// run_ctrl_if: host-side request/acknowledge bundle of the run sequencer.
//   req       host run request (level, four-phase)
//   prog_sel  program select, captured by the sequencer on accept
//   busy      run in progress
//   ack       result valid / handshake acknowledge
//   status    00 ok, 01 timeout, 10 bad prog_sel
//   cycles    RUN cycles of the last run
// The master modport is the host and the slave modport is run_ctrl.
interface run_ctrl_if #(
    parameter int CW = 16
) ();
    logic          req;
    logic [1:0]    prog_sel;
    logic          busy;
    logic          ack;
    logic [1:0]    status;
    logic [CW-1:0] cycles;

    modport master (
        output req, prog_sel,
        input  busy, ack, status, cycles
    );

    modport slave (
        input  req, prog_sel,
        output busy, ack, status, cycles
    );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer in front of the single-cycle core.
// It holds the core in reset while idle. On a host request it pulses the core
// reset, loads the selected entry address into the PC and lets the core run
// until core_done or the watchdog expires. It then reports the cycle count and
// status and waits for the host to drop req.
//   clk         clock, rising edge
//   reset       asynchronous, active-low
//   host        run_ctrl_if slave: req, prog_sel in; busy, ack, status, cycles out
//   core_done   core's done output
//   core_reset  active-high reset to the core
//   start_load  one-cycle strobe: PC loads start_addr
//   start_addr  selected entry address
//
// state      | meaning
// IDLE       | core held in reset, waiting for req
// RESET_CORE | core reset held for RST_CYC cycles
// LOAD       | one cycle, PC loads start_addr
// RUN        | core running, cycles counting, watchdog armed
// DONE       | result valid, ack high until req drops
module run_ctrl #(
    parameter int D       = 12,
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4000,
    parameter int ENTRY0  = 0,
    parameter int ENTRY1  = 128,
    parameter int ENTRY2  = 256
) (
    input  logic         clk,
    input  logic         reset,
    run_ctrl_if.slave    host,
    input  logic         core_done,
    output logic         core_reset,
    output logic         start_load,
    output logic [D-1:0] start_addr
);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CORE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic          busy_q;
    logic          ack_q;
    logic [1:0]    status_q;
    logic [CW-1:0] cycles_q;

    function automatic logic [D-1:0] entry_of(input logic [1:0] sel);
        case (sel)
            2'd0:    entry_of = D'(ENTRY0);
            2'd1:    entry_of = D'(ENTRY1);
            default: entry_of = D'(ENTRY2);
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b1;
            start_load <= 1'b0;
            start_addr <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            status_q   <= 2'b00;
            cycles_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.req) begin
                        if (host.prog_sel != 2'd3) begin
                            // The entry address itself is the latched selection;
                            // later prog_sel changes cannot reach it.
                            start_addr <= entry_of(host.prog_sel);
                            rst_cnt    <= '0;
                            busy_q     <= 1'b1;
                            state      <= RESET_CORE;
                        end else begin
                            // Invalid select: report straight away, core stays frozen.
                            status_q <= 2'b10;
                            cycles_q <= '0;
                            ack_q    <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                RESET_CORE: begin
                    if (rst_cnt == RW'(RST_CYC - 1)) begin
                        core_reset <= 1'b0;
                        start_load <= 1'b1;
                        state      <= LOAD;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    start_load <= 1'b0;
                    cycles_q   <= '0;
                    status_q   <= 2'b00;
                    state      <= RUN;
                end
                RUN: begin
                    // core_done takes priority over the watchdog in the same cycle.
                    if (core_done) begin
                        status_q   <= 2'b00;
                        busy_q     <= 1'b0;
                        ack_q      <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= DONE;
                    end else if (cycles_q == CW'(TIMEOUT - 1)) begin
                        cycles_q   <= CW'(TIMEOUT);
                        status_q   <= 2'b01;
                        busy_q     <= 1'b0;
                        ack_q      <= 1'b1;
                        core_reset <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cycles_q <= cycles_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!host.req) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    core_reset <= 1'b1;
                    start_load <= 1'b0;
                    busy_q     <= 1'b0;
                    ack_q      <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign host.busy   = busy_q;
    assign host.ack    = ack_q;
    assign host.status = status_q;
    assign host.cycles = cycles_q;
endmodule
